bip_control: RTL and testbench

- Fetch/decode/sequence unit that sits directly upstream of the BIP-2 datapath.
- Owns the program counter, instruction register, instruction-memory addressing and a multi-cycle FSM.
- Drives the datapath controls: selA, selB, WRACC, op and operand, plus the data-memory write strobe.
- Holds its own copy of the N/Z flags for conditional branches.

---
 rtl/bip_control.sv | 190 +++++++++++++++++++
 tb/tb_bip_control.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bip_control.sv
// bip_control: fetch/decode/sequence unit in front of the BIP-2 datapath.
// Owns PC, IR, instruction-memory addressing, the multi-cycle FSM and a
// private copy of the N/Z flags used for conditional branches.
//
// Ports:
//   clock_i     system clock, rising edge
//   reset_n_i   asynchronous active-low reset
//   im_addr_o   instruction-memory address (= PC)
//   im_data_i   instruction-memory data, valid one cycle after address
//   flagZ_i     datapath zero flag of current ULA result
//   flagN_i     datapath negative flag of current ULA result
//   selA_o      accumulator source: 00 dm_out_data, 01 operand, 10 ULA
//   selB_o      ULA operand2: 0 dm_out_data, 1 operand
//   WRACC_o     accumulator write-enable pulse (EXEC only)
//   op_o        ULA op: 0 add, 1 sub
//   operand_o   IR[10:0], feeds extensor and dm_addr
//   dm_wr_o     data-memory write strobe (STO, EXEC only)
//   halted_o    high while halted
//
// INSTR_W must equal OPCODE_W + OPERAND_W.
module bip_control #(
   parameter int unsigned ADDR_W    = 11,
   parameter int unsigned OPCODE_W  = 5,
   parameter int unsigned OPERAND_W = 11,
   parameter int unsigned INSTR_W   = 16
) (
   input  logic                 clock_i,
   input  logic                 reset_n_i,
   output logic [ADDR_W-1:0]    im_addr_o,
   input  logic [INSTR_W-1:0]   im_data_i,
   input  logic                 flagZ_i,
   input  logic                 flagN_i,
   output logic [1:0]           selA_o,
   output logic                 selB_o,
   output logic                 WRACC_o,
   output logic                 op_o,
   output logic [OPERAND_W-1:0] operand_o,
   output logic                 dm_wr_o,
   output logic                 halted_o
);

   localparam logic [OPCODE_W-1:0] OP_HLT  = OPCODE_W'(0);
   localparam logic [OPCODE_W-1:0] OP_STO  = OPCODE_W'(1);
   localparam logic [OPCODE_W-1:0] OP_LD   = OPCODE_W'(2);
   localparam logic [OPCODE_W-1:0] OP_LDI  = OPCODE_W'(3);
   localparam logic [OPCODE_W-1:0] OP_ADD  = OPCODE_W'(4);
   localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(5);
   localparam logic [OPCODE_W-1:0] OP_SUB  = OPCODE_W'(6);
   localparam logic [OPCODE_W-1:0] OP_SUBI = OPCODE_W'(7);
   localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(8);
   localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(9);
   localparam logic [OPCODE_W-1:0] OP_BGT  = OPCODE_W'(10);
   localparam logic [OPCODE_W-1:0] OP_BGE  = OPCODE_W'(11);
   localparam logic [OPCODE_W-1:0] OP_BLT  = OPCODE_W'(12);
   localparam logic [OPCODE_W-1:0] OP_BLE  = OPCODE_W'(13);
   localparam logic [OPCODE_W-1:0] OP_JMP  = OPCODE_W'(14);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_MEMRD  = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [INSTR_W-1:0]   ir_q, ir_d;
   logic                 zf_q, zf_d;
   logic                 nf_q, nf_d;

   logic [OPCODE_W-1:0]  ir_opc;
   logic [OPCODE_W-1:0]  fetch_opc;
   logic                 is_arith;
   logic                 taken;
   logic [1:0]           sel_a;
   logic                 sel_b;
   logic                 alu_sub;
   logic                 acc_wr;

   assign ir_opc    = ir_q[INSTR_W-1 -: OPCODE_W];
   assign fetch_opc = im_data_i[INSTR_W-1 -: OPCODE_W];

   // State, PC, IR and flag registers
   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= S_FETCH;
         pc_q    <= '0;
         ir_q    <= '0;
         zf_q    <= 1'b0;
         nf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
         zf_q    <= zf_d;
         nf_q    <= nf_d;
      end
   end

   // Datapath selects decoded from IR; held until the next IR load
   always_comb begin
      sel_a    = 2'b00;
      sel_b    = 1'b0;
      alu_sub  = 1'b0;
      acc_wr   = 1'b0;
      is_arith = 1'b0;
      case (ir_opc)
         OP_LD:   begin sel_a = 2'b00; acc_wr = 1'b1; end
         OP_LDI:  begin sel_a = 2'b01; acc_wr = 1'b1; end
         OP_ADD:  begin sel_a = 2'b10; acc_wr = 1'b1; is_arith = 1'b1; end
         OP_ADDI: begin sel_a = 2'b10; sel_b = 1'b1; acc_wr = 1'b1; is_arith = 1'b1; end
         OP_SUB:  begin sel_a = 2'b10; alu_sub = 1'b1; acc_wr = 1'b1; is_arith = 1'b1; end
         OP_SUBI: begin
            sel_a    = 2'b10;
            sel_b    = 1'b1;
            alu_sub  = 1'b1;
            acc_wr   = 1'b1;
            is_arith = 1'b1;
         end
         default: ;
      endcase
   end

   // Branch decision uses the locally held flags, not the live datapath flags
   always_comb begin
      taken = 1'b0;
      case (ir_opc)
         OP_BEQ:  taken = zf_q;
         OP_BNE:  taken = !zf_q;
         OP_BGT:  taken = !zf_q && !nf_q;
         OP_BGE:  taken = !nf_q;
         OP_BLT:  taken = nf_q;
         OP_BLE:  taken = nf_q || zf_q;
         OP_JMP:  taken = 1'b1;
         default: taken = 1'b0;
      endcase
   end

   // Next-state, PC and flag update
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      ir_d    = ir_q;
      zf_d    = zf_q;
      nf_d    = nf_q;
      case (state_q)
         S_FETCH: state_d = S_DECODE;
         S_DECODE: begin
            ir_d = im_data_i;
            // Memory-operand instructions need a wait cycle for the data memory
            if (fetch_opc == OP_LD || fetch_opc == OP_ADD || fetch_opc == OP_SUB) begin
               state_d = S_MEMRD;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_MEMRD: state_d = S_EXEC;
         S_EXEC: begin
            if (ir_opc == OP_HLT) begin
               state_d = S_HALT;
            end else begin
               state_d = S_FETCH;
               if (taken) begin
                  pc_d = ADDR_W'(ir_q[OPERAND_W-1:0]);
               end else begin
                  pc_d = pc_q + ADDR_W'(1);
               end
            end
            if (is_arith) begin
               zf_d = flagZ_i;
               nf_d = flagN_i;
            end
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // Outputs are pure functions of registered state
   assign im_addr_o = pc_q;
   assign operand_o = ir_q[OPERAND_W-1:0];
   assign selA_o    = sel_a;
   assign selB_o    = sel_b;
   assign op_o      = alu_sub;
   assign WRACC_o   = (state_q == S_EXEC) && acc_wr;
   assign dm_wr_o   = (state_q == S_EXEC) && (ir_opc == OP_STO);
   assign halted_o  = (state_q == S_HALT);

endmodule

// File: tb/tb_bip_control.sv
// Directed bench for bip_control: vector table plus hand-written sequences.
module tb_bip_control;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [10:0] im_addr;
   logic [15:0] im_data;
   logic        flz, fln;
   logic [1:0]  sel_a;
   logic        sel_b, wracc, alu_op, dm_wr, halted;
   logic [10:0] operand;

   logic [15:0] rom [0:2047];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   // Synchronous instruction ROM: data valid one cycle after address
   always @(posedge clk) im_data <= rom[im_addr];

   bip_control dut (
      .clock_i   (clk),
      .reset_n_i (reset_n),
      .im_addr_o (im_addr),
      .im_data_i (im_data),
      .flagZ_i   (flz),
      .flagN_i   (fln),
      .selA_o    (sel_a),
      .selB_o    (sel_b),
      .WRACC_o   (wracc),
      .op_o      (alu_op),
      .operand_o (operand),
      .dm_wr_o   (dm_wr),
      .halted_o  (halted)
   );

   typedef struct {
      logic [4:0]  opc;
      logic [10:0] opd;
      int          lat;
      logic        wr;
      logic        dm;
      logic        csa;
      logic [1:0]  sa;
      logic        calu;
      logic        sb;
      logic        op;
      logic [3:0]  tmask;   // taken per {zf,nf} index
   } vec_t;

   localparam int NVEC = 16;
   vec_t tbl [NVEC];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ins(input logic [4:0] opc, input logic [10:0] opd);
      return {opc, opd};
   endfunction

   task automatic clr_rom();
      for (int i = 0; i < 2048; i++) rom[i] = 16'hF800;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      flz = 1'b0;
      fln = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   // Called at the FETCH cycle of an instruction; ends at the following cycle
   task automatic run_instr(input string name, input int lat, input logic wr, input logic dm,
                            input logic csa, input logic [1:0] sa, input logic calu,
                            input logic sb, input logic op, input logic [10:0] opd,
                            input logic [10:0] nxt, input logic hlt);
      for (int c = 1; c <= lat; c++) begin
         if (c < lat) begin
            chk({name, " early wracc"}, 32'(wracc), 32'(0));
            chk({name, " early dm_wr"}, 32'(dm_wr), 32'(0));
         end else begin
            chk({name, " wracc"}, 32'(wracc), 32'(wr));
            chk({name, " dm_wr"}, 32'(dm_wr), 32'(dm));
            if (csa) chk({name, " selA"}, 32'(sel_a), 32'(sa));
            if (calu) begin
               chk({name, " selB"}, 32'(sel_b), 32'(sb));
               chk({name, " op"}, 32'(alu_op), 32'(op));
            end
         end
         if (c >= 3) chk({name, " operand"}, 32'(operand), 32'(opd));
         @(negedge clk);
      end
      chk({name, " next addr"}, 32'(im_addr), 32'(nxt));
      chk({name, " halted"}, 32'(halted), 32'(hlt));
   endtask

   initial begin
      logic [10:0] nxt;
      // opc, opd, lat, wr, dm, csa, sa, calu, sb, op, tmask
      tbl[0]  = '{5'b00001, 11'd10,  3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000}; // STO
      tbl[1]  = '{5'b00010, 11'd20,  4, 1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000}; // LD
      tbl[2]  = '{5'b00011, 11'd5,   3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 4'b0000}; // LDI
      tbl[3]  = '{5'b00100, 11'd20,  4, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 4'b0000}; // ADD
      tbl[4]  = '{5'b00101, 11'd3,   3, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 4'b0000}; // ADDI
      tbl[5]  = '{5'b00110, 11'd20,  4, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 4'b0000}; // SUB
      tbl[6]  = '{5'b00111, 11'd7,   3, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 4'b0000}; // SUBI
      tbl[7]  = '{5'b01000, 11'd100, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1100}; // BEQ
      tbl[8]  = '{5'b01001, 11'd100, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0011}; // BNE
      tbl[9]  = '{5'b01010, 11'd100, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0001}; // BGT
      tbl[10] = '{5'b01011, 11'd100, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0101}; // BGE
      tbl[11] = '{5'b01100, 11'd100, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1010}; // BLT
      tbl[12] = '{5'b01101, 11'd100, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1110}; // BLE
      tbl[13] = '{5'b01110, 11'd100, 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b1111}; // JMP
      tbl[14] = '{5'b01111, 11'd5,   3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000}; // NOP
      tbl[15] = '{5'b11111, 11'd9,   3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 4'b0000}; // NOP

      // Reset values
      clr_rom();
      rom[0] = ins(5'b00011, 11'd5);
      rom[1] = ins(5'b00101, 11'd3);
      rom[2] = ins(5'b00001, 11'd10);
      rom[3] = ins(5'b11111, 11'd0);
      rom[4] = ins(5'b00100, 11'd20);
      reset_n = 1'b0;
      flz = 1'b0;
      fln = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst im_addr", 32'(im_addr), 32'(0));
      chk("rst wracc", 32'(wracc), 32'(0));
      chk("rst dm_wr", 32'(dm_wr), 32'(0));
      chk("rst halted", 32'(halted), 32'(0));
      chk("rst selA", 32'(sel_a), 32'(0));
      chk("rst selB", 32'(sel_b), 32'(0));
      chk("rst op", 32'(alu_op), 32'(0));
      @(negedge clk);
      reset_n = 1'b1;

      // LDI 5; ADDI 3; STO 10; NOP; ADD 20 at PC=4
      run_instr("seq LDI",  3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 11'd5,  11'd1, 1'b0);
      run_instr("seq ADDI", 3, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b0, 11'd3,  11'd2, 1'b0);
      run_instr("seq STO",  3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd10, 11'd3, 1'b0);
      run_instr("seq NOP",  3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd0,  11'd4, 1'b0);
      run_instr("seq ADD",  4, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 11'd20, 11'd5, 1'b0);

      // Table: SUBI sets flags from (flz,fln), then the instruction under test
      for (int i = 0; i < NVEC; i++) begin
         for (int f = 0; f < 4; f++) begin
            clr_rom();
            rom[0] = ins(5'b00111, 11'd7);
            rom[1] = ins(tbl[i].opc, tbl[i].opd);
            do_reset();
            flz = f[1];
            fln = f[0];
            run_instr("pre SUBI", 3, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 11'd7, 11'd1, 1'b0);
            nxt = tbl[i].tmask[f] ? tbl[i].opd : 11'd2;
            run_instr($sformatf("vec%0d zn%0d", i, f), tbl[i].lat, tbl[i].wr, tbl[i].dm,
                      tbl[i].csa, tbl[i].sa, tbl[i].calu, tbl[i].sb, tbl[i].op,
                      tbl[i].opd, nxt, 1'b0);
         end
      end

      // Non-arithmetic instructions keep SUB flags: BLT taken
      clr_rom();
      rom[0] = ins(5'b00110, 11'd20);
      rom[1] = ins(5'b00011, 11'd5);
      rom[2] = ins(5'b00001, 11'd10);
      rom[3] = ins(5'b01100, 11'd50);
      do_reset();
      flz = 1'b0; fln = 1'b1;
      run_instr("kp SUB", 4, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 11'd20, 11'd1, 1'b0);
      flz = 1'b1; fln = 1'b0;
      run_instr("kp LDI", 3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 11'd5,  11'd2, 1'b0);
      run_instr("kp STO", 3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd10, 11'd3, 1'b0);
      run_instr("kp BLT", 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd50, 11'd50, 1'b0);

      // Same program, SUB result non-negative: BLT not taken
      do_reset();
      flz = 1'b0; fln = 1'b0;
      run_instr("kp2 SUB", 4, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 11'd20, 11'd1, 1'b0);
      flz = 1'b1; fln = 1'b1;
      run_instr("kp2 LDI", 3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 11'd5,  11'd2, 1'b0);
      run_instr("kp2 STO", 3, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd10, 11'd3, 1'b0);
      run_instr("kp2 BLT", 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd50, 11'd4, 1'b0);

      // NOP at 2047 wraps to 0
      clr_rom();
      rom[0]    = ins(5'b01110, 11'd2047);
      rom[2047] = ins(5'b11111, 11'd0);
      do_reset();
      run_instr("wr JMP", 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd2047, 11'd2047, 1'b0);
      run_instr("wr NOP", 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd0,    11'd0,    1'b0);

      // HLT at 300: frozen for 20 cycles
      clr_rom();
      rom[0]   = ins(5'b01110, 11'd300);
      rom[300] = ins(5'b00000, 11'd0);
      do_reset();
      run_instr("h JMP", 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd300, 11'd300, 1'b0);
      run_instr("h HLT", 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd0,   11'd300, 1'b1);
      for (int c = 0; c < 20; c++) begin
         flz = c[0];
         fln = c[1];
         @(negedge clk);
         chk("halt im_addr", 32'(im_addr), 32'(300));
         chk("halt wracc", 32'(wracc), 32'(0));
         chk("halt dm_wr", 32'(dm_wr), 32'(0));
         chk("halt halted", 32'(halted), 32'(1));
      end

      // Reset during EXEC of LDI at PC=40
      clr_rom();
      rom[0]  = ins(5'b01110, 11'd40);
      rom[40] = ins(5'b00011, 11'd5);
      do_reset();
      run_instr("ra JMP", 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd40, 11'd40, 1'b0);
      @(negedge clk);
      @(negedge clk);
      chk("ra exec wracc", 32'(wracc), 32'(1));
      chk("ra exec addr", 32'(im_addr), 32'(40));
      #1 reset_n = 1'b0;
      #1;
      chk("ra rst wracc", 32'(wracc), 32'(0));
      chk("ra rst dm_wr", 32'(dm_wr), 32'(0));
      chk("ra rst im_addr", 32'(im_addr), 32'(0));
      chk("ra rst halted", 32'(halted), 32'(0));
      @(posedge clk);
      #1;
      chk("ra held wracc", 32'(wracc), 32'(0));
      chk("ra held im_addr", 32'(im_addr), 32'(0));
      @(negedge clk);
      reset_n = 1'b1;
      run_instr("ra re JMP", 3, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 11'd40, 11'd40, 1'b0);
      run_instr("ra re LDI", 3, 1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 11'd5,  11'd41, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
